// File: rtl/psddiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psddiv_pkg
//  Description : Shared widths, FSM encoding and saturation constants for the
//                sequential signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package psddiv_pkg;

    localparam int DW_N   = 32;         // dividend / quotient width
    localparam int DW_D   = 16;         // divisor / remainder width
    localparam int DW_R   = DW_D + 1;   // partial remainder holds |divisor| up to 2^15
    localparam int N_ITER = 32;         // one restoring step per dividend bit

    localparam logic [DW_N-1:0] QSAT_POS = 32'h7FFF_FFFF;
    localparam logic [DW_N-1:0] QSAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psddiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : psddiv_if
//  Description : Operand / result bundle between the divider and its
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface psddiv_if;

    logic                          start;
    logic [psddiv_pkg::DW_N-1:0]   dividend;
    logic [psddiv_pkg::DW_D-1:0]   divisor;
    logic [psddiv_pkg::DW_N-1:0]   quotient;
    logic [psddiv_pkg::DW_D-1:0]   rest;
    logic                          busy;
    logic                          done;
    logic                          divzero;

    // Controller side: issues operands, observes results
    modport master (
        output start, dividend, divisor,
        input  quotient, rest, busy, done, divzero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output quotient, rest, busy, done, divzero
    );

endinterface
`default_nettype wire

// File: rtl/psddiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : psddiv_step
//  Description : One combinational restoring-division step on magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module psddiv_step
    import psddiv_pkg::*;
(
    input  wire logic [DW_R-1:0] rem,
    input  wire logic            bit_in,
    input  wire logic [DW_R-1:0] div,
    output logic      [DW_R-1:0] rem_next,
    output logic                 qbit
);

    // One extra guard bit so the sign of the trial difference is unambiguous
    logic [DW_R:0] w_shift;
    logic [DW_R:0] w_trial;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        w_shift  = {rem, bit_in};
        w_trial  = w_shift - {1'b0, div};
        qbit     = ~w_trial[DW_R];
        rem_next = qbit ? w_trial[DW_R-1:0] : w_shift[DW_R-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/psddiv.sv
`default_nettype none
// ============================================================================
//  Module      : psddiv
//  Description : Sequential 32 / 16 signed divider, one restoring step per
//                clock, truncation toward zero, divide-by-zero saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module psddiv
    import psddiv_pkg::*;
(
    input  wire logic clock,
    input  wire logic reset,
    psddiv_if.slave   bus
);

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [DW_N-1:0]   r_q;
    logic [DW_R-1:0]   r_rem;
    logic [DW_R-1:0]   r_div;
    logic              r_qsign;
    logic              r_rsign;
    logic              r_dz;
    logic [DW_N-1:0]   r_quotient;
    logic [DW_D-1:0]   r_rest;
    logic              r_busy;
    logic              r_done;
    logic              r_divzero;

    logic [DW_N-1:0]   w_abs_n;
    logic [DW_R-1:0]   w_d_ext;
    logic [DW_R-1:0]   w_abs_d;
    logic [DW_R-1:0]   w_rem_next;
    logic              w_qbit;

    // Operand magnitudes; -2^31 maps to 2^31 as an unsigned 32-bit value
    always_comb begin
        w_abs_n = bus.dividend[DW_N-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        w_d_ext = {bus.divisor[DW_D-1], bus.divisor};
        w_abs_d = bus.divisor[DW_D-1] ? (~w_d_ext + 1'b1) : w_d_ext;
    end

    psddiv_step u_step (
        .rem      (r_rem),
        .bit_in   (r_q[DW_N-1]),
        .div      (r_div),
        .rem_next (w_rem_next),
        .qbit     (w_qbit)
    );

    // FSM, iteration datapath and result registers; a start in any state
    // (re)loads the operands, after FIX has delivered its results
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_dz       <= 1'b0;
            r_quotient <= '0;
            r_rest     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_divzero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[DW_N-2:0], w_qbit};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(N_ITER - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_quotient <= r_rsign ? QSAT_NEG : QSAT_POS;
                        r_rest     <= '0;
                    end else begin
                        r_quotient <= r_qsign ? (~r_q + 1'b1) : r_q;
                        r_rest     <= r_rsign ? (~r_rem[DW_D-1:0] + 1'b1) : r_rem[DW_D-1:0];
                    end
                    r_divzero <= r_dz;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (bus.start) begin
                r_q     <= w_abs_n;
                r_div   <= w_abs_d;
                r_qsign <= bus.dividend[DW_N-1] ^ bus.divisor[DW_D-1];
                r_rsign <= bus.dividend[DW_N-1];
                r_dz    <= (bus.divisor == '0);
                r_rem   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= ITER;
            end
        end
    end

    assign bus.quotient = r_quotient;
    assign bus.rest     = r_rest;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.divzero  = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_psddiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psddiv
//  Description : Scoreboard testbench for the sequential signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psddiv;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          due;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    psddiv_if bus ();

    psddiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle count, used to check done latency
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one start pulse; optionally enqueue the hand-computed result
    task automatic issue(input logic [31:0] n, input logic [15:0] d, input bit expect_it,
                         input logic [31:0] q, input logic [15:0] r, input logic dz);
        exp_t e;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        @(posedge clock);
        #1;
        if (expect_it) begin
            e.q   = q;
            e.r   = r;
            e.dz  = dz;
            e.due = cyc + 33;
            sb.push_back(e);
        end
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("rest", 32'(bus.rest), 32'(e.r));
                check("divzero", 32'(bus.divzero), 32'(e.dz));
                check("done_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_rest", 32'(bus.rest), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_divzero", 32'(bus.divzero), 32'd0);
        reset = 1'b1;

        // Basic signed cases and boundaries, each run to completion
        issue(32'd1000,       16'd7,      1, 32'd142,       16'd6,      1'b0); repeat (34) @(posedge clock);
        issue(-32'sd1000,     16'd7,      1, 32'hFFFF_FF72, 16'hFFFA,   1'b0); repeat (34) @(posedge clock);
        issue(32'd1000,       16'hFFF9,   1, 32'hFFFF_FF72, 16'd6,      1'b0); repeat (34) @(posedge clock);
        issue(32'h8000_0000,  16'hFFFF,   1, 32'h8000_0000, 16'd0,      1'b0); repeat (34) @(posedge clock);
        issue(32'h8000_0000,  16'h8000,   1, 32'd65536,     16'd0,      1'b0); repeat (34) @(posedge clock);
        issue(32'd5,          16'd0,      1, 32'h7FFF_FFFF, 16'd0,      1'b1); repeat (34) @(posedge clock);
        issue(-32'sd5,        16'd0,      1, 32'h8000_0000, 16'd0,      1'b1); repeat (34) @(posedge clock);
        issue(32'd0,          16'd5,      1, 32'd0,         16'd0,      1'b0); repeat (34) @(posedge clock);

        // Restart while iterating: only the second division completes
        issue(32'd100, 16'd3, 0, 32'd0, 16'd0, 1'b0);
        check("busy_iter", 32'(bus.busy), 32'd1);
        repeat (9) @(posedge clock);
        issue(32'd200, 16'd9, 1, 32'd22, 16'd2, 1'b0);
        repeat (34) @(posedge clock);

        // Back-to-back: second start lands on the FIX edge of the first
        issue(32'd7, 16'd2, 1, 32'd3, 16'd1, 1'b0);
        repeat (32) @(posedge clock);
        issue(-32'sd7, 16'd2, 1, 32'hFFFF_FFFD, 16'hFFFF, 1'b0);
        repeat (34) @(posedge clock);

        // Reset mid-operation: outputs clear, the aborted division never completes
        issue(32'd1000, 16'd7, 0, 32'd0, 16'd0, 1'b0);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_quotient", bus.quotient, 32'd0);
        check("midrst_rest", 32'(bus.rest), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_divzero", 32'(bus.divzero), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(posedge clock);
        check("midrst_idle_busy", 32'(bus.busy), 32'd0);
        issue(32'd1000, 16'd7, 1, 32'd142, 16'd6, 1'b0);

        // Drain the scoreboard with a bounded wait
        begin
            int waited;
            waited = 0;
            while (sb.size() != 0 && waited < 200) begin
                @(posedge clock);
                waited++;
            end
            if (sb.size() != 0) begin
                check("drain_timeout", 32'(sb.size()), 32'd0);
            end
        end
        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
